prewish_mentor: RTL and testbench

- Wishbone-style initiator (mentor) that drives the blinky student's STB/DAT inputs.
- Steps through a table of four 8-bit LED mask patterns.
- For each pattern it strobes the student for a fixed number of cycles, then waits a dwell period before loading the next pattern.
- Sits at top level between board controls (run switch, next button) and the blinky.

---
 rtl/prewish_mentor.sv | 123 ++++++++++++
 tb/tb_prewish_mentor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/prewish_mentor.sv
// prewish_mentor: Wishbone-style initiator that strobes a rotating table of LED masks into the blinky student
// Ports:
//   CLK_I    rising-edge system clock
//   RST_I    asynchronous active-low reset
//   i_run    level, 1 = sequence patterns, 0 = stop once any strobe in progress completes
//   i_next   synchronised button, rising edge forces an early advance during dwell
//   STB_O    registered strobe to the student
//   DAT_O    registered mask data to the student
//   o_index  index of the pattern currently loaded or being loaded
//   o_busy   registered, 1 whenever the FSM is not idle
module prewish_mentor #(
    parameter logic [7:0] MASK0      = 8'b10100000,
    parameter logic [7:0] MASK1      = 8'b11110000,
    parameter logic [7:0] MASK2      = 8'b10101010,
    parameter logic [7:0] MASK3      = 8'b11001100,
    parameter int         STB_CYCLES = 2,
    parameter int         DWELL_BITS = 26
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       i_run,
    input  logic       i_next,
    output logic       STB_O,
    output logic [7:0] DAT_O,
    output logic [1:0] o_index,
    output logic       o_busy
);
    // A zero strobe length still needs one cycle for the student to latch the data
    localparam int STB_N = (STB_CYCLES < 1) ? 1 : STB_CYCLES;
    localparam int CW = $clog2(STB_N + 1);
    localparam logic [CW-1:0] STB_LAST = CW'(STB_N);

    typedef enum logic [1:0] {IDLE, STROBE, DWELL} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         scnt_q, scnt_d;
    logic [DWELL_BITS-1:0] dcnt_q, dcnt_d;
    logic [7:0]            dat_q, dat_d;
    logic [1:0]            idx_q, idx_d;
    logic                  stb_q, stb_d;
    logic                  busy_q, busy_d;
    logic                  next_q;
    logic                  nxt;

    function automatic logic [7:0] mask_of(input logic [1:0] i);
        return (i == 2'd0) ? MASK0 : (i == 2'd1) ? MASK1 : (i == 2'd2) ? MASK2 : MASK3;
    endfunction

    assign nxt = i_next & ~next_q;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        dcnt_d  = dcnt_q;
        dat_d   = dat_q;
        idx_d   = idx_q;
        stb_d   = stb_q;
        case (state_q)
            IDLE: begin
                stb_d = 1'b0;
                // Resuming re-strobes the current index rather than advancing
                if (i_run) begin
                    state_d = STROBE;
                    stb_d   = 1'b1;
                    dat_d   = mask_of(idx_q);
                    scnt_d  = CW'(1);
                end
            end
            STROBE: begin
                // Dropping i_run never truncates a strobe; it only diverts the exit to IDLE
                if (scnt_q == STB_LAST) begin
                    stb_d   = 1'b0;
                    dcnt_d  = '0;
                    state_d = i_run ? DWELL : IDLE;
                end else begin
                    scnt_d = scnt_q + CW'(1);
                end
            end
            DWELL: begin
                if (!i_run) begin
                    state_d = IDLE;
                end else if (nxt || (&dcnt_q)) begin
                    state_d = STROBE;
                    idx_d   = idx_q + 2'd1;
                    dat_d   = mask_of(idx_q + 2'd1);
                    stb_d   = 1'b1;
                    scnt_d  = CW'(1);
                end else begin
                    dcnt_d = dcnt_q + DWELL_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= IDLE;
            scnt_q  <= '0;
            dcnt_q  <= '0;
            dat_q   <= '0;
            idx_q   <= '0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            next_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            dcnt_q  <= dcnt_d;
            dat_q   <= dat_d;
            idx_q   <= idx_d;
            stb_q   <= stb_d;
            busy_q  <= busy_d;
            next_q  <= i_next;
        end
    end

    assign STB_O   = stb_q;
    assign DAT_O   = dat_q;
    assign o_index = idx_q;
    assign o_busy  = busy_q;
endmodule

// File: tb/tb_prewish_mentor.sv
// tb_prewish_mentor: scoreboard bench for prewish_mentor with short dwell, checking each strobe's data, index, spacing and width
module tb_prewish_mentor;
    typedef struct {
        logic [7:0] dat;
        logic [1:0] idx;
        int         gap;
        int         w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       nxt_btn = 1'b0;
    logic       sel = 1'b0;
    logic       stb_a, stb_b, busy_a, busy_b;
    logic [7:0] dat_a, dat_b;
    logic [1:0] idx_a, idx_b;
    logic       stb_m, busy_m;
    logic [7:0] dat_m;
    logic [1:0] idx_m;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last = 0;
    int   cur_w = 0;
    logic prev = 1'b0;
    exp_t q[$];
    exp_t free_run[5];

    always #5 clk = ~clk;

    prewish_mentor #(.STB_CYCLES(2), .DWELL_BITS(4)) dut_a (
        .CLK_I(clk), .RST_I(rst_n), .i_run(run), .i_next(nxt_btn),
        .STB_O(stb_a), .DAT_O(dat_a), .o_index(idx_a), .o_busy(busy_a)
    );

    prewish_mentor #(.STB_CYCLES(0), .DWELL_BITS(4)) dut_b (
        .CLK_I(clk), .RST_I(rst_n), .i_run(run), .i_next(nxt_btn),
        .STB_O(stb_b), .DAT_O(dat_b), .o_index(idx_b), .o_busy(busy_b)
    );

    assign stb_m  = sel ? stb_b : stb_a;
    assign dat_m  = sel ? dat_b : dat_a;
    assign idx_m  = sel ? idx_b : idx_a;
    assign busy_m = sel ? busy_b : busy_a;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int max);
        int n = 0;
        while ((q.size() != 0 || stb_m) && n < max) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(n < max), 1);
    endtask

    task automatic wait_rise(input string nm, input int max);
        int n = 0;
        while (!stb_m && n < max) begin
            tick();
            n++;
        end
        chk({nm, "_timeout"}, int'(n < max), 1);
    endtask

    // Monitor: pops one expectation per STB_O rise, checks spacing from the previous rise and the strobe width
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            cyc  = 0;
            last = 0;
            prev = 1'b0;
        end else begin
            cyc++;
            if (stb_m && !prev) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_stb: got strobe dat=0x%0h idx=%0d want none at t=%0t", dat_m, idx_m, $time);
                    cur_w = -1;
                end else begin
                    e = q.pop_front();
                    chk("dat", int'(dat_m), int'(e.dat));
                    chk("idx", int'(idx_m), int'(e.idx));
                    if (e.gap > 0) chk("gap", cyc - last, e.gap);
                    cur_w = e.w;
                end
                last = cyc;
            end
            if (!stb_m && prev && cur_w >= 0) chk("width", cyc - last, cur_w);
            prev = stb_m;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        free_run[0] = '{8'hA0, 2'd0, 1, 2};
        free_run[1] = '{8'hF0, 2'd1, 18, 2};
        free_run[2] = '{8'hAA, 2'd2, 18, 2};
        free_run[3] = '{8'hCC, 2'd3, 18, 2};
        free_run[4] = '{8'hA0, 2'd0, 18, 2};

        tick();
        tick();
        chk("rst_stb", int'(stb_a), 0);
        chk("rst_dat", int'(dat_a), 0);
        chk("rst_idx", int'(idx_a), 0);
        chk("rst_busy", int'(busy_a), 0);

        for (int i = 0; i < 5; i++) q.push_back(free_run[i]);
        run = 1'b1;
        rst_n = 1'b1;
        wait_done("free_run", 200);

        repeat (4) tick();
        q.push_back('{8'hF0, 2'd1, 7, 2});
        q.push_back('{8'hAA, 2'd2, 18, 2});
        nxt_btn = 1'b1;
        repeat (3) tick();
        nxt_btn = 1'b0;
        wait_done("next_pulse", 100);

        q.push_back('{8'hCC, 2'd3, 18, 2});
        wait_rise("drop_run", 100);
        run = 1'b0;
        wait_done("drop_run_fall", 20);
        tick();
        chk("stop_busy", int'(busy_m), 0);
        chk("stop_idx", int'(idx_m), 3);
        repeat (20) tick();
        chk("idle_stb", int'(stb_m), 0);
        chk("idle_dat", int'(dat_m), 8'hCC);
        q.push_back('{8'hCC, 2'd3, -1, 2});
        run = 1'b1;
        wait_done("resume", 20);

        q.push_back('{8'hA0, 2'd0, 18, 2});
        wait_rise("async_rst", 100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_stb", int'(stb_a), 0);
        chk("async_dat", int'(dat_a), 0);
        chk("async_idx", int'(idx_a), 0);
        chk("async_busy", int'(busy_a), 0);
        tick();
        q.push_back('{8'hA0, 2'd0, 1, 2});
        rst_n = 1'b1;
        wait_done("restart", 20);

        rst_n = 1'b0;
        sel = 1'b1;
        tick();
        q.push_back('{8'hA0, 2'd0, 1, 1});
        q.push_back('{8'hF0, 2'd1, 17, 1});
        q.push_back('{8'hAA, 2'd2, 17, 1});
        rst_n = 1'b1;
        wait_done("stb_zero", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
